// File: rtl/vq18_elem_select.sv
// vq18_elem_select
//   Consumer end of the VQ18 sort network. It collects the 18 ranked element
//   addresses (largest state first) and turns on the first K ranked elements.
//   The resulting select vector goes to the DAC element driver through a
//   valid/ready handshake. Malformed address frames are flagged.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, k_in       : frame start pulse and element count (sampled in IDLE)
//   addr_in/valid/ready : ranked address stream, rank 0 first
//   sel_out/valid/ready : element-select vector handoff
//   busy              : frame in progress (COLLECT or HOLD)
//   err_range/err_dup/err_k : sticky frame error flags, cleared by the next start
module vq18_elem_select #(
  parameter int N_ELEM = 18,
  parameter int AW     = 5,
  parameter int KW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_in,
  input  logic [AW-1:0]     addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic [N_ELEM-1:0] sel_out,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              busy,
  output logic              err_range,
  output logic              err_dup,
  output logic              err_k
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     rank;
  logic [KW-1:0]     k_lat;
  logic [N_ELEM-1:0] seen;
  logic [N_ELEM-1:0] acc;
  logic [N_ELEM-1:0] acc_nxt;
  logic [N_ELEM-1:0] addr_bit;
  logic              accept;
  logic              in_range;
  logic              is_dup;
  logic              last;
  logic              rank_lt_k;

  // Element count saturates at the number of physical elements.
  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if (k > KW'(N_ELEM)) return KW'(N_ELEM);
    else return k;
  endfunction

  function automatic logic k_over(input logic [KW-1:0] k);
    return (k > KW'(N_ELEM));
  endfunction

  // Address decode: out-of-range addresses map to an empty mask so they
  // can never touch seen/acc.
  assign in_range  = (addr_in < AW'(N_ELEM));
  assign addr_bit  = in_range ? (N_ELEM'(1) << addr_in) : '0;
  assign is_dup    = |(seen & addr_bit);
  assign last      = (rank == AW'(N_ELEM - 1));
  assign rank_lt_k = (32'(rank) < 32'(k_lat));
  assign accept    = addr_valid && addr_ready;
  assign acc_nxt   = (in_range && !is_dup && rank_lt_k) ? (acc | addr_bit) : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    addr_ready = 1'b0;
    sel_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        addr_ready = 1'b1;
        busy       = 1'b1;
        if (addr_valid && last) state_nxt = HOLD;
      end
      HOLD: begin
        sel_valid = 1'b1;
        busy      = 1'b1;
        if (sel_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: rank counter, seen mask, accumulator and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rank      <= '0;
      k_lat     <= '0;
      seen      <= '0;
      acc       <= '0;
      sel_out   <= '0;
      err_range <= 1'b0;
      err_dup   <= 1'b0;
      err_k     <= 1'b0;
    end else if (state == IDLE && start) begin
      k_lat     <= clamp_k(k_in);
      err_k     <= k_over(k_in);
      err_range <= 1'b0;
      err_dup   <= 1'b0;
      seen      <= '0;
      acc       <= '0;
      rank      <= '0;
    end else if (accept) begin
      // Malformed entries still consume a rank.
      rank <= rank + AW'(1);
      if (!in_range)   err_range <= 1'b1;
      else if (is_dup) err_dup   <= 1'b1;
      else             seen      <= seen | addr_bit;
      acc <= acc_nxt;
      if (last) sel_out <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_vq18_elem_select.sv
module tb_vq18_elem_select;

  localparam int N = 18;

  logic          clk = 1'b0;
  logic          rst, start, addr_valid, addr_ready, sel_valid, sel_ready;
  logic          busy, err_range, err_dup, err_k;
  logic [4:0]    k_in, addr_in;
  logic [N-1:0]  sel_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vq18_elem_select dut (
    .clk(clk), .rst(rst), .start(start), .k_in(k_in),
    .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .sel_out(sel_out), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .busy(busy), .err_range(err_range), .err_dup(err_dup), .err_k(err_k)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: spec rules applied directly to the ranked list.
  task automatic ref_model(input int k, input int a[N], output logic [31:0] sel,
                           output bit dup, output bit rng, output bit ek);
    bit used[N];
    int kk;
    kk  = (k > N) ? N : k;
    ek  = (k > N);
    sel = 0; dup = 0; rng = 0;
    foreach (used[i]) used[i] = 0;
    for (int r = 0; r < N; r++) begin
      if (a[r] >= N) rng = 1;
      else if (used[a[r]]) dup = 1;
      else begin
        used[a[r]] = 1;
        if (r < kk) sel |= (32'd1 << a[r]);
      end
    end
  endtask

  task automatic perm(output int a[N]);
    int t, j;
    for (int i = 0; i < N; i++) a[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_sel_out"}, 32'(sel_out), 0);
    chk({tag, "_flags"}, {26'd0, sel_valid, addr_ready, busy, err_range, err_dup, err_k}, 0);
  endtask

  // One full frame; hold_wait=0 means sel_ready is already high on HOLD entry.
  task automatic do_frame(input string tag, input int k, input int a[N],
                          input bit gaps, input int hold_wait);
    logic [31:0] es;
    bit ed, er, ek;
    ref_model(k, a, es, ed, er, ek);
    @(posedge clk); #1;
    start = 1'b1; k_in = 5'(k);
    @(posedge clk); #1;
    start = 1'b0; k_in = 5'($urandom);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g = $urandom_range(2, 0);
        for (int c = 0; c < g; c++) begin
          addr_valid = 1'b0; addr_in = 5'($urandom);
          if (c == 0) start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      addr_valid = 1'b1; addr_in = 5'(a[i]);
      if (i == N - 1 && hold_wait == 0) sel_ready = 1'b1;
      @(negedge clk);
      if (i == 0 || i == N - 1) chk({tag, "_addr_ready"}, 32'(addr_ready), 1);
      @(posedge clk); #1;
      addr_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_sel_valid"}, 32'(sel_valid), 1);
    chk({tag, "_sel_out"}, 32'(sel_out), es);
    chk({tag, "_errs"}, {29'd0, err_range, err_dup, err_k}, {29'd0, er, ed, ek});
    chk({tag, "_hold_ready"}, 32'(addr_ready), 0);
    for (int c = 0; c < hold_wait; c++) begin
      @(posedge clk); #1;
      addr_valid = 1'($urandom); addr_in = 5'($urandom);
      start = (c == hold_wait / 2);
      @(negedge clk);
      chk({tag, "_hold_stable"}, {13'd0, sel_valid, addr_ready, busy, sel_out},
          {13'd0, 1'b1, 1'b0, 1'b1, es[N-1:0]});
    end
    if (hold_wait != 0) begin
      @(posedge clk); #1;
      start = 1'b0; addr_valid = 1'b0; sel_ready = 1'b1;
    end
    @(posedge clk); #1;
    sel_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, {29'd0, sel_valid, busy, addr_ready}, 0);
    chk({tag, "_sel_kept"}, 32'(sel_out), es);
    chk({tag, "_errs_kept"}, {29'd0, err_range, err_dup, err_k}, {29'd0, er, ed, ek});
  endtask

  initial begin
    int a[N];
    rst = 1'b1; start = 1'b0; k_in = '0; addr_in = '0;
    addr_valid = 1'b0; sel_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_zero("reset");

    // 1: descending addresses, K=5
    for (int i = 0; i < N; i++) a[i] = N - 1 - i;
    do_frame("t1", 5, a, 0, 0);
    chk("t1_const", 32'(sel_out), 32'h3E000);

    // 2: K=0 and K=18 on permutations
    perm(a); do_frame("t2_k0", 0, a, 0, 0);
    chk("t2_k0_const", 32'(sel_out), 0);
    perm(a); do_frame("t2_k18", 18, a, 0, 0);
    chk("t2_k18_pop", $countones(sel_out), 18);

    // 3: k_in over range clamps, next start clears err_k
    perm(a); do_frame("t3_k25", 25, a, 0, 0);
    chk("t3_errk", 32'(err_k), 1);
    perm(a); do_frame("t3_k3", 3, a, 0, 0);
    chk("t3_k3_pop", $countones(sel_out), 3);

    // 4: duplicate at rank 1, out-of-range at rank 3
    a = '{2, 2, 7, 20, 9, 0, 1, 3, 4, 5, 6, 8, 10, 11, 12, 13, 14, 15};
    do_frame("t4", 4, a, 0, 0);
    chk("t4_const", 32'(sel_out), 32'h84);

    // 5: gaps in addr_valid, 10 HOLD cycles with sel_ready low
    perm(a); do_frame("t5", 7, a, 1, 10);

    // 6: reset after 9 addresses, then a clean frame
    perm(a);
    @(posedge clk); #1; start = 1'b1; k_in = 5'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      addr_valid = 1'b1; addr_in = 5'(a[i]);
      @(posedge clk); #1;
    end
    addr_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk_idle_zero("t6_rst");
    perm(a); do_frame("t6", 2, a, 0, 0);
    chk("t6_pop", $countones(sel_out), 2);

    // Random frames, including malformed addresses and large K
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        a[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : i;
      if (f % 2 == 0) perm(a);
      do_frame("rnd", $urandom_range(31, 0), a, 1, $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
